hpc1_and_stream: RTL and testbench



---
 rtl/hpc1_and_stream_if.sv | 33 +++
 rtl/hpc1_and_stream.sv | 105 ++++++++++
 tb/tb_hpc1_and_stream.sv | 243 ++++++++++++++++++++++++
 3 files changed

// File: rtl/hpc1_and_stream_if.sv
// Stream bundle for hpc1_and_stream: operand shares, randomness and result channels.
// The master drives operands, randomness and out_ready; the slave is the gadget.
interface hpc1_and_stream_if #(
    parameter int unsigned SECURITY_ORDER = 2,
    parameter int unsigned WIDTH          = 8,
    parameter int unsigned CNT_W          = 16
);
    localparam int unsigned D      = SECURITY_ORDER + 1;
    localparam int unsigned R_PAIR = D * (D - 1) / 2;
    localparam int unsigned RND_W  = WIDTH * 2 * R_PAIR;

    logic [WIDTH*D-1:0] ina;
    logic [WIDTH*D-1:0] inb;
    logic               in_valid;
    logic               in_ready;
    logic [RND_W-1:0]   rnd;
    logic               rnd_valid;
    logic               rnd_ready;
    logic [WIDTH*D-1:0] outt;
    logic               out_valid;
    logic               out_ready;
    logic [CNT_W-1:0]   op_cnt;

    modport master (
        output ina, inb, in_valid, rnd, rnd_valid, out_ready,
        input  in_ready, rnd_ready, outt, out_valid, op_cnt
    );

    modport slave (
        input  ina, inb, in_valid, rnd, rnd_valid, out_ready,
        output in_ready, rnd_ready, outt, out_valid, op_cnt
    );
endinterface

// File: rtl/hpc1_and_stream.sv
// Multi-lane two-stage HPC1 masked AND: refresh B and delay A in stage 1,
// DOM cross products in stage 2, share-wise compression on the output.
module hpc1_and_stream #(
    parameter int unsigned SECURITY_ORDER = 2,
    parameter int unsigned WIDTH          = 8,
    parameter int unsigned CNT_W          = 16
) (
    input logic              clk,
    input logic              rst_n,
    hpc1_and_stream_if.slave bus
);
    localparam int unsigned D      = SECURITY_ORDER + 1;
    localparam int unsigned R_PAIR = D * (D - 1) / 2;
    localparam int unsigned NS     = WIDTH * D;

    // Lexicographic index of share pair (j,k), j<k.
    function automatic int unsigned pair_idx(input int unsigned j, input int unsigned k);
        return j * D - (j * (j + 1)) / 2 + (k - j - 1);
    endfunction

    logic                    v1_q, v1_d, v2_q, v2_d;
    logic [NS-1:0]           a1_q, b1_q, b1_d;
    logic [WIDTH*R_PAIR-1:0] m1_q, m1_d;
    logic [NS*D-1:0]         c_q, c_d;
    logic [CNT_W-1:0]        cnt_q;
    logic                    fire_in, adv2, drain;

    assign adv2          = v1_q & (~v2_q | bus.out_ready);
    assign bus.in_ready  = rst_n & (~v1_q | adv2);
    assign bus.rnd_ready = bus.in_ready & bus.in_valid;
    assign fire_in       = bus.in_valid & bus.rnd_valid & bus.in_ready;
    assign drain         = v2_q & bus.out_ready;
    assign bus.out_valid = v2_q;
    assign bus.op_cnt    = cnt_q;

    for (genvar i = 0; i < WIDTH; i++) begin : g_lane
        localparam int unsigned RB = i * 2 * R_PAIR;

        assign m1_d[i*R_PAIR +: R_PAIR] = bus.rnd[RB + R_PAIR +: R_PAIR];

        for (genvar j = 0; j < D; j++) begin : g_share
            logic [D-1:0] ref_bits;

            for (genvar k = 0; k < D; k++) begin : g_term
                localparam int unsigned PLO = (j < k) ? j : k;
                localparam int unsigned PHI = (j < k) ? k : j;
                localparam int unsigned CI  = (i * D + j) * D + k;

                if (j == k) begin : g_diag
                    assign ref_bits[k] = 1'b0;
                    assign c_d[CI]     = a1_q[i*D+j] & b1_q[i*D+k];
                end else begin : g_cross
                    assign ref_bits[k] = bus.rnd[RB + pair_idx(PLO, PHI)];
                    assign c_d[CI]     = (a1_q[i*D+j] & b1_q[i*D+k])
                                         ^ m1_q[i*R_PAIR + pair_idx(PLO, PHI)];
                end
            end

            // Each refresh bit lands on exactly two shares, so the unmasked B is unchanged.
            assign b1_d[i*D+j]     = bus.inb[i*D+j] ^ (^ref_bits);
            assign bus.outt[i*D+j] = ^c_q[(i*D+j)*D +: D];
        end
    end

    always_comb begin
        v1_d = v1_q;
        v2_d = v2_q;
        if (fire_in) begin
            v1_d = 1'b1;
        end else if (adv2) begin
            v1_d = 1'b0;
        end
        if (adv2) begin
            v2_d = 1'b1;
        end else if (drain) begin
            v2_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v1_q  <= 1'b0;
            v2_q  <= 1'b0;
            a1_q  <= '0;
            b1_q  <= '0;
            m1_q  <= '0;
            c_q   <= '0;
            cnt_q <= '0;
        end else begin
            v1_q <= v1_d;
            v2_q <= v2_d;
            if (fire_in) begin
                a1_q <= bus.ina;
                b1_q <= b1_d;
                m1_q <= m1_d;
            end
            if (adv2) begin
                c_q <= c_d;
            end
            if (drain) begin
                cnt_q <= cnt_q + CNT_W'(1);
            end
        end
    end
endmodule

// File: tb/tb_hpc1_and_stream.sv
// Directed bench for hpc1_and_stream: d=2 shares, 4 lanes, 4-bit completion counter.
module tb_hpc1_and_stream;
    localparam int unsigned SO = 1;
    localparam int unsigned W  = 4;
    localparam int unsigned CW = 4;
    localparam int unsigned D  = SO + 1;
    localparam int unsigned RW = W * 2 * (D * (D - 1) / 2);
    localparam int unsigned NS = W * D;

    logic clk = 1'b0;
    logic rst_n;
    int   n_checks = 0;
    int   n_errors = 0;

    always #5 clk = ~clk;

    hpc1_and_stream_if #(.SECURITY_ORDER(SO), .WIDTH(W), .CNT_W(CW)) bus ();

    hpc1_and_stream #(.SECURITY_ORDER(SO), .WIDTH(W), .CNT_W(CW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [NS-1:0] mask(input logic [W-1:0] v, input logic [W-1:0] r);
        logic [NS-1:0] s;
        for (int i = 0; i < W; i++) begin
            s[i*D]   = r[i];
            s[i*D+1] = v[i] ^ r[i];
        end
        return s;
    endfunction

    function automatic logic [W-1:0] unmask(input logic [NS-1:0] s);
        logic [W-1:0] v;
        for (int i = 0; i < W; i++) v[i] = s[i*D] ^ s[i*D+1];
        return v;
    endfunction

    function automatic logic [W-1:0] word_b(input int i, input bit alt);
        return alt ? W'(i * 7 + 3) : W'(15 - i);
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        bus.in_valid  = 1'b0;
        bus.rnd_valid = 1'b0;
    endtask

    task automatic drive_word(input logic [W-1:0] a, input logic [W-1:0] b);
        bus.ina = mask(a, W'($urandom));
        bus.inb = mask(b, W'($urandom));
        bus.rnd = RW'($urandom);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        idle();
        step();
        step();
        rst_n = 1'b1;
    endtask

    task automatic single_op(input logic [W-1:0] a, input logic [W-1:0] b, input bit zero_rnd,
                             input logic [CW-1:0] cnt_exp);
        drive_word(a, b);
        if (zero_rnd) bus.rnd = '0;
        bus.in_valid  = 1'b1;
        bus.rnd_valid = 1'b1;
        bus.out_ready = 1'b1;
        #1;
        check_eq("single_rnd_ready", 32'(bus.rnd_ready), 32'd1);
        step();
        idle();
        #1;
        check_eq("single_lat_early", 32'(bus.out_valid), 32'd0);
        step();
        check_eq("single_out_valid", 32'(bus.out_valid), 32'd1);
        check_eq("single_data", 32'(unmask(bus.outt)), 32'(a & b));
        step();
        check_eq("single_op_cnt", 32'(bus.op_cnt), 32'(cnt_exp));
        check_eq("single_drained", 32'(bus.out_valid), 32'd0);
    endtask

    task automatic run_stream(input int n, input bit alt, input int stall_from, input int stall_len);
        int            sent = 0;
        int            rcv = 0;
        int            first = -1;
        int            last = -1;
        int            stall_acc = 0;
        bit            stalled, fire, have_held;
        logic [NS-1:0] held;
        have_held = 1'b0;
        held      = '0;
        for (int cyc = 0; cyc < 80 && rcv < n; cyc++) begin
            stalled       = (cyc >= stall_from) && (cyc < stall_from + stall_len);
            bus.out_ready = !stalled;
            bus.in_valid  = (sent < n);
            bus.rnd_valid = 1'b1;
            drive_word(W'(sent), word_b(sent, alt));
            #1;
            fire = bus.in_valid & bus.rnd_valid & bus.in_ready;
            if (stalled && bus.out_valid) begin
                if (have_held) check_eq("stall_hold", 32'(bus.outt), 32'(held));
                held      = bus.outt;
                have_held = 1'b1;
            end
            if (stalled && fire) stall_acc++;
            if (stall_len > 0 && cyc == stall_from + stall_len - 1)
                check_eq("stall_in_ready", 32'(bus.in_ready), 32'd0);
            if (bus.out_valid && bus.out_ready) begin
                check_eq("stream_data", 32'(unmask(bus.outt)), 32'(W'(rcv) & word_b(rcv, alt)));
                if (first < 0) first = cyc;
                last = cyc;
                rcv++;
            end
            @(posedge clk);
            #1;
            if (fire) sent++;
        end
        idle();
        bus.out_ready = 1'b1;
        check_eq("stream_count", 32'(rcv), 32'(n));
        if (stall_len > 0) check_eq("stall_accepted", 32'(stall_acc), 32'd2);
        else check_eq("stream_back_to_back", 32'(last - first), 32'(n - 1));
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n         = 1'b0;
        bus.out_ready = 1'b1;
        bus.in_valid  = 1'b1;
        bus.rnd_valid = 1'b1;
        drive_word(W'($urandom), W'($urandom));
        repeat (3) begin
            step();
            drive_word(W'($urandom), W'($urandom));
        end
        #1;
        check_eq("rst_outt", 32'(bus.outt), 32'd0);
        check_eq("rst_out_valid", 32'(bus.out_valid), 32'd0);
        check_eq("rst_in_ready", 32'(bus.in_ready), 32'd0);
        check_eq("rst_rnd_ready", 32'(bus.rnd_ready), 32'd0);
        check_eq("rst_op_cnt", 32'(bus.op_cnt), 32'd0);
        idle();
        rst_n = 1'b1;
        #1;
        check_eq("rel_in_ready", 32'(bus.in_ready), 32'd1);

        single_op(4'hA, 4'hC, 1'b0, 4'd1);
        single_op(4'hA, 4'hC, 1'b1, 4'd2);

        do_reset();
        run_stream(8, 1'b0, 0, 0);
        check_eq("stream_op_cnt", 32'(bus.op_cnt), 32'd8);

        do_reset();
        run_stream(6, 1'b1, 0, 5);
        check_eq("bp_op_cnt", 32'(bus.op_cnt), 32'd6);

        // Randomness starvation: data offered, no randomness.
        do_reset();
        bus.out_ready = 1'b1;
        drive_word(4'h3, 4'h6);
        bus.in_valid  = 1'b1;
        bus.rnd_valid = 1'b0;
        for (int c = 0; c < 3; c++) begin
            #1;
            check_eq("starve_rnd_ready", 32'(bus.rnd_ready), 32'd1);
            check_eq("starve_in_ready", 32'(bus.in_ready), 32'd1);
            check_eq("starve_out_valid", 32'(bus.out_valid), 32'd0);
            step();
        end
        check_eq("starve_op_cnt", 32'(bus.op_cnt), 32'd0);
        bus.rnd_valid = 1'b1;
        step();
        idle();
        step();
        check_eq("starve_out_valid_late", 32'(bus.out_valid), 32'd1);
        check_eq("starve_data", 32'(unmask(bus.outt)), 32'h2);
        step();
        check_eq("starve_op_cnt_done", 32'(bus.op_cnt), 32'd1);

        // Mid-flight reset with both stages occupied.
        bus.out_ready = 1'b0;
        bus.in_valid  = 1'b1;
        bus.rnd_valid = 1'b1;
        drive_word(4'h9, 4'hB);
        step();
        drive_word(4'hC, 4'hE);
        step();
        idle();
        #1;
        check_eq("mid_full_valid", 32'(bus.out_valid), 32'd1);
        check_eq("mid_full_in_ready", 32'(bus.in_ready), 32'd0);
        #2;
        rst_n = 1'b0;
        #1;
        check_eq("mid_rst_out_valid", 32'(bus.out_valid), 32'd0);
        check_eq("mid_rst_op_cnt", 32'(bus.op_cnt), 32'd0);
        check_eq("mid_rst_outt", 32'(bus.outt), 32'd0);
        check_eq("mid_rst_in_ready", 32'(bus.in_ready), 32'd0);
        step();
        rst_n         = 1'b1;
        bus.out_ready = 1'b1;
        drive_word(4'h5, 4'h7);
        bus.in_valid  = 1'b1;
        bus.rnd_valid = 1'b1;
        step();
        idle();
        step();
        check_eq("post_rst_valid", 32'(bus.out_valid), 32'd1);
        check_eq("post_rst_data", 32'(unmask(bus.outt)), 32'h5);
        step();
        check_eq("post_rst_no_stale", 32'(bus.out_valid), 32'd0);
        check_eq("post_rst_op_cnt", 32'(bus.op_cnt), 32'd1);

        // Counter wrap after 2^CNT_W completions.
        do_reset();
        run_stream(16, 1'b1, 0, 0);
        check_eq("wrap_op_cnt", 32'(bus.op_cnt), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
